// File: rtl/sync_stream_fifo.sv
// sync_stream_fifo: single-clock valid/ready stream buffer with configurable depth,
// fill level, almost-full/almost-empty flags and a synchronous flush.
// Output is first-word-fall-through: o_data is the head entry whenever o_valid is high.
module sync_stream_fifo #(
    parameter int width    = 8,
    parameter int depth    = 4,
    parameter int af_level = 3,
    parameter int ae_level = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [width-1:0]           i_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [width-1:0]           o_data,
    output logic [$clog2(depth+1)-1:0] level,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);

    logic signed [width-1:0] mem [depth];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    push;
    logic                    pop;

    // Pointers wrap explicitly at depth-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Handshake and status decodes, all derived from count.
    always_comb begin
        i_ready      = (count != CNT_W'(depth));
        o_valid      = (count != '0);
        level        = count;
        almost_full  = (count >= CNT_W'(af_level));
        almost_empty = (count <= CNT_W'(ae_level));
        push         = i_valid && i_ready;
        pop          = o_valid && o_ready;
        o_data       = mem[rd_ptr];
    end

    // Control state: pointers and count; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; not reset. A push never targets the head slot while entries are held,
    // because i_ready is low when full.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= i_data;
        end
    end

endmodule
